// File: rtl/ysyx_idu_rnu_queue.sv
// rtl/ysyx_idu_rnu_queue.sv - multi-lane decode->rename circular FIFO with flush
module ysyx_idu_rnu_queue #(
  parameter int DEPTH = 8,
  parameter int IN_W  = 2,
  parameter int OUT_W = 2,
  parameter int PW    = 256,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                flush,
  input  logic [IN_W-1:0]     in_valid,
  input  logic [IN_W*PW-1:0]  in_data,
  output logic                in_ready,
  output logic [OUT_W-1:0]    out_valid,
  output logic [OUT_W*PW-1:0] out_data,
  input  logic [OUT_W-1:0]    out_ready,
  output logic [CW-1:0]       count
);

  logic [PW-1:0] mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [CW-1:0] n_in, n_out;
  logic          in_run, out_run;
  logic [IN_W-1:0] wr_en;

  // Credit check on registered occupancy only; no dequeue credit in the same cycle
  always_comb begin
    in_ready = (CW'(DEPTH) - count_q) >= CW'(IN_W);
    count    = count_q;
  end

  // Enqueue: contiguous run of valid lanes from lane 0, suppressed when not ready or flushing
  always_comb begin
    n_in   = '0;
    in_run = in_ready && !flush;
    wr_en  = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (in_run && in_valid[i]) begin
        n_in     = n_in + CW'(1);
        wr_en[i] = 1'b1;
      end else begin
        in_run = 1'b0;
      end
    end
  end

  // Read side: lane j shows the j-th oldest entry; dequeue counts the contiguous taken run
  always_comb begin
    n_out   = '0;
    out_run = !flush;
    for (int j = 0; j < OUT_W; j++) begin
      out_valid[j]          = CW'(j) < count_q;
      out_data[j*PW +: PW]  = mem_q[head_q + AW'(j)];
      if (out_run && out_valid[j] && out_ready[j]) begin
        n_out = n_out + CW'(1);
      end else begin
        out_run = 1'b0;
      end
    end
  end

  // Next pointer/occupancy; flush wins over any simultaneous enqueue or dequeue
  always_comb begin
    head_d  = head_q + n_out[AW-1:0];
    tail_d  = tail_q + n_in[AW-1:0];
    count_d = count_q + n_in - n_out;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage; lane i lands at tail+i modulo DEPTH, so wrapping groups stay contiguous
  always_ff @(posedge clock) begin
    for (int i = 0; i < IN_W; i++) begin
      if (wr_en[i]) begin
        mem_q[tail_q + AW'(i)] <= in_data[i*PW +: PW];
      end
    end
  end

  // Occupancy never exceeds DEPTH and always matches the pointer distance
  assert property (@(posedge clock) disable iff (reset)
    (count_q <= CW'(DEPTH)) && ((tail_q - head_q) == count_q[AW-1:0]));

endmodule

// File: tb/tb_ysyx_idu_rnu_queue.sv
// tb/tb_ysyx_idu_rnu_queue.sv - randomized and directed bench against a queue model
module tb_ysyx_idu_rnu_queue;

  localparam int DEPTH = 8;
  localparam int IN_W  = 2;
  localparam int OUT_W = 2;
  localparam int PW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic                clock;
  logic                reset;
  logic                flush;
  logic [IN_W-1:0]     in_valid;
  logic [IN_W*PW-1:0]  in_data;
  logic                in_ready;
  logic [OUT_W-1:0]    out_valid;
  logic [OUT_W*PW-1:0] out_data;
  logic [OUT_W-1:0]    out_ready;
  logic [CW-1:0]       count;

  int n_checks;
  int n_errors;

  logic [PW-1:0] mq[$];

  ysyx_idu_rnu_queue #(
    .DEPTH(DEPTH), .IN_W(IN_W), .OUT_W(OUT_W), .PW(PW)
  ) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .count(count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    int sz;
    logic [OUT_W-1:0] ev;
    sz = mq.size();
    ev = '0;
    for (int j = 0; j < OUT_W; j++) ev[j] = (j < sz);
    check({tag, ".count"}, 64'(count), 64'(sz));
    check({tag, ".in_ready"}, 64'(in_ready), 64'((DEPTH - sz) >= IN_W));
    check({tag, ".out_valid"}, 64'(out_valid), 64'(ev));
    for (int j = 0; j < OUT_W; j++) begin
      if (j < sz) check({tag, ".out_data"}, 64'(out_data[j*PW +: PW]), 64'(mq[j]));
    end
  endtask

  // One clock: drive inputs, check current outputs, advance the model alongside the DUT
  task automatic step(input string tag, input logic fl, input logic [1:0] iv,
                      input logic [PW-1:0] d0, input logic [PW-1:0] d1,
                      input logic [1:0] orr);
    int ni;
    int no;
    logic [PW-1:0] dv[2];
    flush     = fl;
    in_valid  = iv;
    in_data   = {d1, d0};
    out_ready = orr;
    #1;
    check_outputs(tag);
    ni = 0;
    if (!fl && (DEPTH - mq.size() >= IN_W) && iv[0]) ni = iv[1] ? 2 : 1;
    no = 0;
    if (!fl && orr[0] && mq.size() >= 1) no = (orr[1] && mq.size() >= 2) ? 2 : 1;
    dv[0] = d0;
    dv[1] = d1;
    @(posedge clock);
    #1;
    if (fl) begin
      mq.delete();
    end else begin
      repeat (no) void'(mq.pop_front());
      for (int i = 0; i < ni; i++) mq.push_back(dv[i]);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // reset then idle
    step("idle", 0, 2'b00, 0, 0, 2'b00);
    step("idle", 0, 2'b00, 0, 0, 2'b11);

    // fill to 5 then async reset mid-cycle
    step("fill5", 0, 2'b11, 32'h11, 32'h12, 2'b00);
    step("fill5", 0, 2'b11, 32'h13, 32'h14, 2'b00);
    step("fill5", 0, 2'b01, 32'h15, 32'h16, 2'b00);
    check("pre_reset.count", 64'(count), 64'd5);
    reset = 1'b1;
    #1;
    check("async_reset.count", 64'(count), 64'd0);
    check("async_reset.out_valid", 64'(out_valid), 64'd0);
    check("async_reset.in_ready", 64'(in_ready), 64'd1);
    mq.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;

    // fill to full with A0..A7, 5th group refused
    for (int g = 0; g < 4; g++)
      step("fill", 0, 2'b11, 32'hA0 + 2*g, 32'hA1 + 2*g, 2'b00);
    check("full.in_ready", 64'(in_ready), 64'd0);
    step("full5th", 0, 2'b11, 32'hEE, 32'hEF, 2'b00);
    check("full5th.count", 64'(count), 64'd8);

    // drain in pairs
    for (int g = 0; g < 4; g++)
      step("drain", 0, 2'b00, 0, 0, 2'b11);
    check("drained.count", 64'(count), 64'd0);

    // lane 0 low blocks enqueue; ready only on lane 1 blocks dequeue
    step("gap_in", 0, 2'b10, 32'hC0, 32'hC1, 2'b00);
    step("pair", 0, 2'b11, 32'hC2, 32'hC3, 2'b00);
    step("gap_out", 0, 2'b00, 0, 0, 2'b10);
    check("gap_out.count", 64'(count), 64'd2);
    step("gap_out2", 1, 2'b00, 0, 0, 2'b00);

    // move head/tail to 7 with single-lane traffic, then straddle the wrap
    for (int k = 0; k < 7; k++) step("walk_in", 0, 2'b01, 32'hD0 + k, 0, 2'b00);
    for (int k = 0; k < 7; k++) step("walk_out", 0, 2'b00, 0, 0, 2'b01);
    step("wrap", 0, 2'b11, 32'hB0, 32'hB1, 2'b00);
    check("wrap.lane0", 64'(out_data[0 +: PW]), 64'h000000B0);
    check("wrap.lane1", 64'(out_data[PW +: PW]), 64'h000000B1);
    step("wrap_pop", 0, 2'b01, 32'hB2, 0, 2'b01);

    // flush beats simultaneous enqueue and dequeue
    check("preflush.count", 64'(count), 64'd2);
    step("flush", 1, 2'b11, 32'hF0, 32'hF1, 2'b11);
    check("flush.count", 64'(count), 64'd0);
    check("flush.out_valid", 64'(out_valid), 64'd0);

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      step("rand", ($urandom_range(0, 24) == 0), 2'($urandom), $urandom, $urandom, 2'($urandom));
    end
    step("final", 0, 2'b00, 0, 0, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
